// File: rtl/regfile_dump.sv
// regfile_dump: RV32I register file with a valid/ready register dump engine; REGFILE_BYPASS_EN makes reads write-first
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int DUMP_START = 0,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [AW-1:0]                    i_rs1_addr,
  output logic [DATA_W-1:0]                o_rs1_data,
  input  logic [AW-1:0]                    i_rs2_addr,
  output logic [DATA_W-1:0]                o_rs2_data,
  input  logic                             i_rd_wren,
  input  logic [AW-1:0]                    i_rd_addr,
  input  logic [DATA_W-1:0]                i_rd_data,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  o_regs,
  input  logic                             i_dump_req,
  output logic                             o_dump_busy,
  output logic                             o_dump_valid,
  input  logic                             i_dump_ready,
  output logic [AW-1:0]                    o_dump_idx,
  output logic [DATA_W-1:0]                o_dump_data,
  output logic                             o_dump_last
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, state_n;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [AW-1:0] ptr;
  logic wr;
  assign wr = i_rd_wren && i_rd_addr != '0;
  function automatic logic [DATA_W-1:0] rd(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    rd = (wr && i_rd_addr == a) ? i_rd_data : regs[a];
`else
    rd = regs[a];
`endif
  endfunction
  assign o_rs1_data = rd(i_rs1_addr);
  assign o_rs2_data = rd(i_rs2_addr);
  assign o_regs = regs;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (i_dump_req ? LOAD : IDLE) :
              state == LOAD ? SEND :
              i_dump_ready ? (o_dump_last ? IDLE : LOAD) : SEND;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      regs <= '0;
      ptr <= '0;
      o_dump_busy <= 1'b0;
      o_dump_valid <= 1'b0;
      o_dump_last <= 1'b0;
      o_dump_idx <= '0;
      o_dump_data <= '0;
    end else begin
      state <= state_n;
      if (wr) regs[i_rd_addr] <= i_rd_data;
      case (state)
        IDLE: if (i_dump_req) begin
          ptr <= AW'(DUMP_START);
          o_dump_busy <= 1'b1;
        end
        LOAD: begin
          o_dump_idx <= ptr;
          o_dump_data <= rd(ptr);
          o_dump_valid <= 1'b1;
          o_dump_last <= ptr == AW'(NUM_REGS-1);
        end
        SEND: if (i_dump_ready) begin
          o_dump_valid <= 1'b0;
          if (o_dump_last) o_dump_busy <= 1'b0;
          else ptr <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- RV32I integer register file: 32 x 32-bit, two combinational read ports, one synchronous write port, x0 hardwired to zero.
- Drives the flat register image (o_regs) that the regfile scoreboard checks.
- Adds a serial dump engine: on request, streams every register as {index, data} over a valid/ready handshake to a bench monitor or trace logger.
- Sits in the singlecycle core in place of the plain regfile.

Parameters:
- DATA_W, 32, register width
- NUM_REGS, 32, register count; index width is $clog2(NUM_REGS)
- DUMP_START, 0, first index streamed by the dump engine (0 or 1)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_rs1_addr  in  5  read port 1 address
- o_rs1_data  out  32  read port 1 data, combinational
- i_rs2_addr  in  5  read port 2 address
- o_rs2_data  out  32  read port 2 data, combinational
- i_rd_wren  in  1  write enable
- i_rd_addr  in  5  write address
- i_rd_data  in  32  write data
- o_regs  out  32x32  flat image, [i] = register i, [0] always 0
- i_dump_req  in  1  start a dump, sampled when idle
- o_dump_busy  out  1  high from request acceptance until the last beat is accepted
- o_dump_valid  out  1  beat valid
- i_dump_ready  in  1  consumer ready
- o_dump_idx  out  5  register index of the current beat
- o_dump_data  out  32  register value of the current beat
- o_dump_last  out  1  high on the beat with idx = NUM_REGS-1

Behaviour:
- Reset:
  - All registers clear to 0.
  - FSM goes to IDLE.
  - o_dump_valid, o_dump_busy, o_dump_last, o_dump_idx and o_dump_data all clear to 0.
  - Reset has priority over every other input in the same cycle.
- Write: when i_rd_wren=1 and i_rd_addr!=0, reg[i_rd_addr] <= i_rd_data on the rising edge. A write to x0 is dropped.
- Read: o_rsN_data = reg[i_rsN_addr], combinational. Address 0 returns 0.
- o_regs reflects register state after the edge; no extra latency.
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - i_dump_req=1 -> LOAD; ptr <= DUMP_START; o_dump_busy <= 1.
  - A request arriving while busy is ignored (no queueing).
- LOAD:
  - Capture o_dump_idx <= ptr and o_dump_data <= reg[ptr].
  - Capture takes the pre-edge value; a same-cycle write to ptr is not seen.
  - o_dump_valid <= 1; o_dump_last <= (ptr == NUM_REGS-1); -> SEND.
  - First beat is valid 2 cycles after the cycle where the request was sampled.
- SEND:
  - Hold idx, data and last stable while valid=1 and ready=0.
  - On valid & ready with last=0: ptr <= ptr+1, valid <= 0, -> LOAD. This gives 2 cycles per beat.
  - On valid & ready with last=1: valid <= 0, busy <= 0, -> IDLE.
  - Ready may be high before valid; it has effect only when valid=1.
- A write to an index after its beat is captured is not reflected in that dump. A write before capture is reflected.
- x0 is always streamed as 0.
- Assertion of i_rst mid-dump aborts the dump immediately; no partial last beat.
- Index arithmetic is unsigned 5-bit; ptr never wraps because last terminates the dump at NUM_REGS-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read ports are write-first: if i_rd_wren=1, i_rd_addr!=0 and i_rd_addr==i_rsN_addr, then o_rsN_data=i_rd_data in the same cycle.
  - The LOAD capture also uses the bypassed value.
- Undefined:
  - Read-before-write: reads return the pre-edge value.
  - LOAD capture uses the pre-edge value, as stated above.
- o_regs is never bypassed.

Test Plan:
- Reset then read: hold i_rst 1 cycle, read all 32 addresses -> every o_rsN_data=0, o_regs all 0, o_dump_valid=0, o_dump_busy=0.
- Write/read plus x0: write x5=0xDEADBEEF, then x0=0x12345678 -> next cycle rs1=5 gives 0xDEADBEEF, rs2=0 gives 0, o_regs[0]=0.
- Same-cycle read and write: write x7=0xA5A5A5A5 while reading rs1=7 (old value 0) -> 0 without REGFILE_BYPASS_EN, 0xA5A5A5A5 with it.
- Full dump, ready tied 1, DUMP_START=0, after writes xi=i*0x11 -> 32 beats:
  - idx 0..31 in order, data i*0x11 (idx 0 gives 0);
  - last only on idx 31;
  - busy drops the cycle after beat 31;
  - 64 cycles from request to busy low.
- Dump backpressure: ready held 0 for 5 cycles on beat idx 3 -> idx, data and last stable all 5 cycles; beat 3 advances only on the handshake. A second i_dump_req while busy produces no extra beats.
- Reset mid-dump: assert i_rst during beat idx 10 -> next cycle valid=0, busy=0, FSM IDLE, all registers 0. A new request then restarts at idx DUMP_START.
